axi_rd_arb: RTL and testbench
=============================

# axi_rd_arb

Two-master read-channel arbiter that shares the core's single AXI read port (AR/R) between the instruction-side and data-side uncached bridges. It sits between the cache bridges and the external AXI bus. It grants one whole read burst at a time and registers the winning AR request. It routes R beats only to the owner until `rlast`, so bursts from different masters are never interleaved. Write channels (AW/W/B) do not pass through this block.

## Interface
Parameters:
- `ADDR_W`, 32: AR address width.
- `DATA_W`, 64: R data width.
- `ID_W`, 4: AXI ID width.

Ports (`mX_` = master X, where m0 is the icache bridge and m1 is the dcache bridge; `s_` = downstream bus):
- `clock`  in  1  sole clock; everything samples on its rising edge.
- `reset`  in  1  synchronous, active-low; 0 resets the block on the next rising `clock` edge.
- `mX_arid/araddr/arlen/arsize/arburst`  in  ID_W/ADDR_W/8/3/2  AR payload from master X.
- `mX_arvalid`  in  1; `mX_arready`  out  1.
- `mX_rid/rdata/rresp/rlast`  out  ID_W/DATA_W/2/1  R payload to master X.
- `mX_rvalid`  out  1; `mX_rready`  in  1.
- `s_arid/araddr/arlen/arsize/arburst`  out  ID_W/ADDR_W/8/3/2  registered AR payload.
- `s_arvalid`  out  1; `s_arready`  in  1.
- `s_rid/rdata/rresp/rlast`  in  ID_W/DATA_W/2/1; `s_rvalid`  in  1; `s_rready`  out  1.
- `busy`  out  1  high when state is not IDLE.
- `owner`  out  1  index of the current or last granted master.

## Operation
- State machine states: IDLE, ADDR, DATA.
- IDLE:
  - Grant is computed combinationally from `m0_arvalid` and `m1_arvalid`.
  - The winner sees `arready=1` in the same cycle. The loser sees `arready=0`.
  - When the AR handshake completes, the payload is captured into `s_ar*` registers, `owner` is set to the winner, and the state moves to ADDR.
  - With no request, the state stays in IDLE.
- ADDR:
  - `s_arvalid=1` and the `s_ar*` registers are held stable.
  - On `s_arready`, the state moves to DATA.
  - Both `mX_arready` are 0.
- DATA:
  - `m[owner]_r*` = `s_r*`, `m[owner]_rvalid` = `s_rvalid`, and `s_rready` = `m[owner]_rready`. This path is combinational.
  - The non-owner sees `rvalid=0`. Its R payload is don't-care and is driven as 0.
  - A beat handshake with `s_rlast=1` returns the state to IDLE.
  - A new grant can occur in the IDLE cycle that follows.
- Outside DATA: `s_rready=0` and all `mX_rvalid=0`.
- No ID remapping is done. IDs pass through unchanged, and at most one burst is outstanding.
- `arlen` is forwarded unchanged. Burst length is bounded only by `rlast`.
- Reset:
  - Applies in any state, including mid-burst.
  - Forces IDLE, `s_arvalid=0`, `s_rready=0`, all `mX_arready=0`, all `mX_rvalid=0`, `busy=0`, `owner=1`, and all `s_ar*` registers to 0.
  - A downstream burst abandoned by reset is not drained. The downstream slave shares the same reset.

## Timing
- Request acceptance: `mX_arvalid` rising in IDLE is accepted in the same cycle.
- `s_arvalid` is asserted from the next cycle, so AR latency is 1 cycle.
- R path: 0-cycle combinational routing, 1 beat per cycle sustained.
- Minimum burst turnaround: the cycle after the `rlast` handshake is IDLE, so there is one dead cycle between bursts.
- `s_arvalid` never deasserts before `s_arready`, and the `s_ar*` registers do not change while it is high.
- Simultaneous requests in IDLE: resolved by the priority rule (see Configuration). Exactly one `mX_arready` is high.
- A master that drops `arvalid` without a handshake has no effect.

## Configuration
- `AXI_RD_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the master that is not `owner` wins.
  - Since reset sets `owner=1`, m0 wins the first tie.
- `AXI_RD_ARB_RR_EN` undefined: fixed priority, with m1 (dcache) always winning ties.
- Both modes have identical state machine and timing. Only the tie-break differs.

## Test plan
- Single m0 request, `araddr=0x8000_0000`, `arlen=3`, with the slave returning 4 beats with `rlast` on beat 4:
  - `m0_arready` is high in cycle 0 and `s_arvalid` in cycle 1.
  - m0 receives 4 beats and m1 receives none.
  - `busy` falls the cycle after `rlast`.
- Both masters request continuously, with `arlen=0`:
  - With RR, grants alternate m0, m1, m0, m1.
  - Without the macro, grants go to m1 every time.
- Slave holds `s_arready=0` for 5 cycles:
  - `s_arvalid` and `s_araddr` stay constant, and no `mX_arready` is asserted.
  - A new m1 request stays pending.
- Owner m1 applies `rready` backpressure (alternating 0/1) over an 8-beat burst:
  - `s_rready` mirrors `m1_rready`.
  - All 8 beats arrive in order with `m1_rlast` only on beat 8.
  - `m0_rvalid` stays 0 throughout.
- `reset=0` asserted mid-DATA, after beat 2 of 4:
  - Next cycle, `busy=0`, all valids/readies are 0, and `owner=1`.
  - After release, a fresh m0 request is granted normally.
- Pass-through fields: the burst uses `arid=0xA`, `arsize=3`, `arburst=1`, and the slave returns `rresp=2`.
  - `s_arid`, `s_arsize` and `s_arburst` appear unchanged downstream.
  - `rresp=2` and `rid=0xA` are delivered unchanged to the owner.

Source files
------------

// File: rtl/axi_rd_arb.sv
// Two-master AXI read arbiter: grants one whole burst at a time, registers AR, routes R to owner until rlast.
// Optional macro AXI_RD_ARB_RR_EN selects round-robin tie-break (default: m1 wins ties).
module axi_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ID_W-1:0]   s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic              owner_reg;
  logic [ID_W-1:0]   arid_reg;
  logic [ADDR_W-1:0] araddr_reg;
  logic [7:0]        arlen_reg;
  logic [2:0]        arsize_reg;
  logic [1:0]        arburst_reg;
  logic              any_req;
  logic              grant_m1;

  always_comb begin
    any_req = m0_arvalid | m1_arvalid;
`ifdef AXI_RD_ARB_RR_EN
    // On a tie the master that did not own the last burst wins.
    grant_m1 = m1_arvalid & (~m0_arvalid | ~owner_reg);
`else
    grant_m1 = m1_arvalid;
`endif
  end

  always_comb begin
    state_next = state_reg;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Readies are masked while reset is held so no handshake can be lost.
        m0_arready = reset & m0_arvalid & ~grant_m1;
        m1_arready = reset & grant_m1;
        if (any_req) state_next = ADDR;
      end
      ADDR: begin
        if (s_arready) state_next = DATA;
      end
      DATA: begin
        s_rready = owner_reg ? m1_rready : m0_rready;
        if (s_rvalid && s_rready && s_rlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b1;
      arid_reg    <= '0;
      araddr_reg  <= '0;
      arlen_reg   <= '0;
      arsize_reg  <= '0;
      arburst_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_req) begin
        owner_reg   <= grant_m1;
        arid_reg    <= grant_m1 ? m1_arid    : m0_arid;
        araddr_reg  <= grant_m1 ? m1_araddr  : m0_araddr;
        arlen_reg   <= grant_m1 ? m1_arlen   : m0_arlen;
        arsize_reg  <= grant_m1 ? m1_arsize  : m0_arsize;
        arburst_reg <= grant_m1 ? m1_arburst : m0_arburst;
      end
    end
  end

  always_comb begin
    m0_rid    = '0;
    m0_rdata  = '0;
    m0_rresp  = '0;
    m0_rlast  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rid    = '0;
    m1_rdata  = '0;
    m1_rresp  = '0;
    m1_rlast  = 1'b0;
    m1_rvalid = 1'b0;
    if (state_reg == DATA) begin
      if (owner_reg) begin
        m1_rid    = s_rid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m1_rvalid = s_rvalid;
      end else begin
        m0_rid    = s_rid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m0_rvalid = s_rvalid;
      end
    end
  end

  assign s_arid    = arid_reg;
  assign s_araddr  = araddr_reg;
  assign s_arlen   = arlen_reg;
  assign s_arsize  = arsize_reg;
  assign s_arburst = arburst_reg;
  assign s_arvalid = (state_reg == ADDR);
  assign busy      = (state_reg != IDLE);
  assign owner     = owner_reg;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Bench for axi_rd_arb: arbitration table, hand-written burst/stall/backpressure/reset sequences,
// then random traffic checked against a burst-level reference model.
module tb_axi_rd_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;

  logic clock = 1'b0;
  logic reset;
  logic [ID_W-1:0] m0_arid, m1_arid, s_arid, m0_rid, m1_rid, s_rid;
  logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
  logic [7:0] m0_arlen, m1_arlen, s_arlen;
  logic [2:0] m0_arsize, m1_arsize, s_arsize;
  logic [1:0] m0_arburst, m1_arburst, s_arburst;
  logic m0_arvalid, m1_arvalid, s_arvalid, m0_arready, m1_arready, s_arready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0] m0_rresp, m1_rresp, s_rresp;
  logic m0_rlast, m1_rlast, s_rlast, m0_rvalid, m1_rvalid, s_rvalid;
  logic m0_rready, m1_rready, s_rready, busy, owner;

  axi_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_arvalid = 0;
    m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_arvalid = 0;
    m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rvalid = 0;
  endtask

  typedef struct {
    logic v0, v1;
    logic r0, r1;
    logic own;
  } vec_t;
  vec_t vt[6];

  // Random-phase reference model: one burst record at transaction level
  bit in_flight, addr_done, m_own, req0, req1, win1, rr_mode, e_dat;
  logic [ADDR_W-1:0] m_addr;
  int bursts, beat;

  initial begin
`ifdef AXI_RD_ARB_RR_EN
    rr_mode = 1;
    vt[0] = '{0,0, 0,0, 1}; vt[1] = '{1,0, 1,0, 0}; vt[2] = '{1,1, 0,1, 1};
    vt[3] = '{1,1, 1,0, 0}; vt[4] = '{0,1, 0,1, 1}; vt[5] = '{1,1, 1,0, 0};
`else
    rr_mode = 0;
    vt[0] = '{0,0, 0,0, 1}; vt[1] = '{1,0, 1,0, 0}; vt[2] = '{1,1, 0,1, 1};
    vt[3] = '{1,1, 0,1, 1}; vt[4] = '{0,1, 0,1, 1}; vt[5] = '{1,0, 1,0, 0};
`endif
    idle_inputs();
    reset = 0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_s_rready", s_rready, 0);
    reset = 1;

    // Arbitration table: each vector is one request cycle then a 1-beat burst
    for (int i = 0; i < 6; i++) begin
      cyc();
      m0_arvalid = vt[i].v0; m1_arvalid = vt[i].v1;
      m0_araddr = 32'h1000 + i; m1_araddr = 32'h2000 + i;
      #1;
      chk("tbl_m0_arready", m0_arready, vt[i].r0);
      chk("tbl_m1_arready", m1_arready, vt[i].r1);
      cyc();
      m0_arvalid = 0; m1_arvalid = 0;
      #1;
      chk("tbl_s_arvalid", s_arvalid, vt[i].r0 | vt[i].r1);
      chk("tbl_owner", owner, vt[i].own);
      if (vt[i].r0 | vt[i].r1) begin
        chk("tbl_s_araddr", s_araddr, vt[i].r1 ? 32'h2000 + i : 32'h1000 + i);
        s_arready = 1;
        cyc();
        s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 64'(i);
        m0_rready = 1; m1_rready = 1;
        #1;
        chk("tbl_m0_rvalid", m0_rvalid, !vt[i].own);
        chk("tbl_m1_rvalid", m1_rvalid, vt[i].own);
        cyc();
        s_rvalid = 0; s_rlast = 0; m0_rready = 0; m1_rready = 0;
        #1;
      end
      chk("tbl_busy_end", busy, 0);
      $display("vector %0d: req=%b%b grant=%b%b owner=%0d", i, vt[i].v1, vt[i].v0, m1_arready, m0_arready, owner);
    end

    // m0 4-beat burst with pass-through fields, 5-cycle AR stall, pending m1
    cyc();
    m0_arid = 4'hA; m0_araddr = 32'h8000_0000; m0_arlen = 3; m0_arsize = 3; m0_arburst = 1; m0_arvalid = 1;
    #1;
    chk("a_m0_arready", m0_arready, 1);
    chk("a_m1_arready", m1_arready, 0);
    cyc();
    m0_arvalid = 0; m1_arvalid = 1; m1_araddr = 32'h4444_0000;
    #1;
    chk("a_s_arid", s_arid, 4'hA);
    chk("a_s_arlen", s_arlen, 3);
    chk("a_s_arsize", s_arsize, 3);
    chk("a_s_arburst", s_arburst, 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_s_arvalid", s_arvalid, 1);
      chk("stall_s_araddr", s_araddr, 32'h8000_0000);
      chk("stall_m0_arready", m0_arready, 0);
      chk("stall_m1_arready", m1_arready, 0);
      chk("stall_s_rready", s_rready, 0);
      cyc();
      #1;
    end
    s_arready = 1;
    cyc();
    s_arready = 0;
    for (int j = 0; j < 4; j++) begin
      s_rvalid = 1; s_rdata = 64'hD0 + 64'(j); s_rid = 4'hA; s_rresp = 2; s_rlast = (j == 3); m0_rready = 1;
      #1;
      chk("a_m0_rvalid", m0_rvalid, 1);
      chk("a_m0_rdata", m0_rdata, 64'hD0 + 64'(j));
      chk("a_m0_rid", m0_rid, 4'hA);
      chk("a_m0_rresp", m0_rresp, 2);
      chk("a_m0_rlast", m0_rlast, j == 3);
      chk("a_m1_rvalid", m1_rvalid, 0);
      chk("a_s_rready", s_rready, 1);
      cyc();
    end
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    #1;
    chk("a_busy_after", busy, 0);
    chk("a_pending_m1_grant", m1_arready, 1);
    $display("burst m0 addr=80000000 len=4 done, m1 granted next");

    // m1 8-beat burst with alternating rready backpressure
    cyc();
    m1_arvalid = 0;
    #1;
    chk("b_owner", owner, 1);
    chk("b_s_araddr", s_araddr, 32'h4444_0000);
    s_arready = 1;
    cyc();
    s_arready = 0;
    beat = 0;
    for (int c = 0; c < 16; c++) begin
      m1_rready = c[0]; s_rvalid = 1; s_rdata = 64'hB0 + 64'(beat); s_rlast = (beat == 7);
      #1;
      chk("b_s_rready", s_rready, m1_rready);
      chk("b_m1_rvalid", m1_rvalid, 1);
      chk("b_m1_rdata", m1_rdata, 64'hB0 + 64'(beat));
      chk("b_m1_rlast", m1_rlast, beat == 7);
      chk("b_m0_rvalid", m0_rvalid, 0);
      if (m1_rready) beat++;
      cyc();
    end
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    #1;
    chk("b_beats", beat, 8);
    chk("b_busy_after", busy, 0);
    $display("burst m1 addr=44440000 len=8 with backpressure done");

    // Reset mid-DATA after 2 of 4 beats
    cyc();
    m0_arvalid = 1; m0_araddr = 32'h5000;
    cyc();
    m0_arvalid = 0; s_arready = 1;
    cyc();
    s_arready = 0;
    for (int j = 0; j < 2; j++) begin
      s_rvalid = 1; s_rlast = 0; m0_rready = 1;
      cyc();
    end
    s_rvalid = 0; reset = 0; m0_arvalid = 1;
    cyc();
    chk("c_busy", busy, 0);
    chk("c_owner", owner, 1);
    chk("c_s_arvalid", s_arvalid, 0);
    chk("c_s_rready", s_rready, 0);
    chk("c_m0_arready", m0_arready, 0);
    chk("c_m1_arready", m1_arready, 0);
    chk("c_m0_rvalid", m0_rvalid, 0);
    chk("c_s_araddr", s_araddr, 0);
    reset = 1;
    #1;
    chk("c_regrant", m0_arready, 1);
    cyc();
    m0_arvalid = 0;
    #1;
    chk("c_s_arvalid_after", s_arvalid, 1);
    chk("c_owner_after", owner, 0);
    chk("c_s_araddr_after", s_araddr, 32'h5000);
    s_arready = 1;
    cyc();
    s_arready = 0; s_rvalid = 1; s_rlast = 1;
    cyc();
    idle_inputs();
    $display("reset mid-burst recovered, m0 regranted");

    // Random traffic against the burst-level model
    reset = 0;
    cyc();
    reset = 1;
    in_flight = 0; addr_done = 0; m_own = 1; req0 = 0; req1 = 0; bursts = 0; m_addr = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!req0) req0 = ($urandom % 3) == 0;
      if (!req1) req1 = ($urandom % 3) == 0;
      m0_arvalid = req0; m1_arvalid = req1;
      m0_araddr = $urandom; m1_araddr = $urandom;
      s_arready = $urandom % 2; s_rvalid = $urandom % 2; s_rlast = ($urandom % 4) == 0;
      s_rdata = {$urandom, $urandom}; m0_rready = $urandom % 2; m1_rready = $urandom % 2;
      #1;
      win1 = req1 && (!req0 || (rr_mode ? !m_own : 1'b1));
      e_dat = in_flight && addr_done;
      chk("r_m0_arready", m0_arready, !in_flight && req0 && !win1);
      chk("r_m1_arready", m1_arready, !in_flight && win1);
      chk("r_s_arvalid", s_arvalid, in_flight && !addr_done);
      chk("r_busy", busy, in_flight);
      chk("r_owner", owner, m_own);
      if (in_flight && !addr_done) chk("r_s_araddr", s_araddr, m_addr);
      chk("r_s_rready", s_rready, e_dat && (m_own ? m1_rready : m0_rready));
      chk("r_m0_rvalid", m0_rvalid, e_dat && !m_own && s_rvalid);
      chk("r_m1_rvalid", m1_rvalid, e_dat && m_own && s_rvalid);
      if (e_dat) chk("r_rdata", m_own ? m1_rdata : m0_rdata, s_rdata);
      if (!in_flight) begin
        if (req0 || req1) begin
          in_flight = 1; addr_done = 0; m_own = win1;
          m_addr = win1 ? m1_araddr : m0_araddr;
          if (win1) req1 = 0; else req0 = 0;
        end
      end else if (!addr_done) begin
        if (s_arready) addr_done = 1;
      end else if (s_rvalid && s_rlast && (m_own ? m1_rready : m0_rready)) begin
        in_flight = 0;
        bursts++;
        $display("random burst %0d: master m%0d addr=%08h", bursts, m_own, m_addr);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
